// File: rtl/hvpi_ctrl.sv
// Hardware vectored priority interrupt controller.
// Latches rising edges on the request lines, picks one eligible channel by
// fixed or round-robin priority, and walks it through a
// request / acknowledge / end-of-interrupt cycle, presenting its ISR vector.
module hvpi_ctrl #(
    parameter int          NUM_INTS   = 8,
    parameter int          PC_WIDTH   = 8,
    parameter int unsigned VEC_BASE   = 32'hE0,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INTS-1:0]         ints,
    input  logic [NUM_INTS-1:0]         mask_in,
    input  logic                        ld_mask,
    input  logic                        clr_mask,
    input  logic                        int_enable,
    input  logic                        int_disable,
    input  logic                        rr_mode,
    input  logic                        ack,
    input  logic                        eoi,
    output logic                        int_pending,
    output logic [PC_WIDTH-1:0]         isr_addr,
    output logic [$clog2(NUM_INTS)-1:0] int_id,
    output logic                        in_service,
    output logic [NUM_INTS-1:0]         pend_reg
);

    localparam int ID_W = $clog2(NUM_INTS);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                state_q, state_d;
    logic [NUM_INTS-1:0]   pend_q, pend_d;
    logic [NUM_INTS-1:0]   mask_q, mask_d;
    logic [NUM_INTS-1:0]   prev_q;
    logic                  en_q, en_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  int_pending_q, int_pending_d;
    logic                  in_service_q, in_service_d;
    logic [ID_W-1:0]       int_id_q, int_id_d;
    logic [PC_WIDTH-1:0]   isr_addr_q, isr_addr_d;

    logic [NUM_INTS-1:0]   rise;
    logic [NUM_INTS-1:0]   eligible;
    logic [NUM_INTS-1:0]   ack_clr;
    logic                  sel_found;
    logic [ID_W-1:0]       sel_id;
    logic [ID_W-1:0]       cand;
    logic [PC_WIDTH-1:0]   sel_addr;
    int                    cand_idx;

    assign rise     = ints & ~prev_q;
    assign eligible = pend_q & mask_q;

    // Mask and global-enable next values; clear/disable dominate load/enable.
    always_comb begin
        mask_d = mask_q;
        if (clr_mask)
            mask_d = '0;
        else if (ld_mask)
            mask_d = mask_in;

        en_d = en_q;
        if (int_disable)
            en_d = 1'b0;
        else if (int_enable)
            en_d = 1'b1;
    end

    // Channel selection: scan upward from 0 (fixed) or from rr_ptr (round-robin).
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand_idx  = 0;
        cand      = '0;
        for (int off = 0; off < NUM_INTS; off++) begin
            cand_idx = rr_mode ? (int'(rr_ptr_q) + off) % NUM_INTS : off;
            cand     = ID_W'(cand_idx);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
        // Wraps naturally to PC_WIDTH bits.
        sel_addr = PC_WIDTH'(VEC_BASE + VEC_STRIDE * 32'(sel_id));
    end

    // Service-cycle FSM next state, held request outputs and pending-bit update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_d       = state_q;
        int_pending_d = int_pending_q;
        in_service_d  = in_service_q;
        int_id_d      = int_id_q;
        isr_addr_d    = isr_addr_q;
        rr_ptr_d      = rr_ptr_q;
        ack_clr       = '0;

        unique case (state_q)
            IDLE: begin
                if (en_q && sel_found) begin
                    int_id_d      = sel_id;
                    isr_addr_d    = sel_addr;
                    int_pending_d = 1'b1;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    ack_clr[int_id_q] = 1'b1;
                    int_pending_d     = 1'b0;
                    in_service_d      = 1'b1;
                    state_d           = SERVICE;
                end else if (!en_d || !mask_d[int_id_q]) begin
                    // Withdraw the request; the pend bit stays for a later retry.
                    int_pending_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    rr_ptr_d     = ID_W'((int'(int_id_q) + 1) % NUM_INTS);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge on the bit being acknowledged survives the clear.
        pend_d = (pend_q & ~ack_clr) | rise;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            mask_q        <= '0;
            prev_q        <= '0;
            en_q          <= 1'b0;
            rr_ptr_q      <= '0;
            int_pending_q <= 1'b0;
            in_service_q  <= 1'b0;
            int_id_q      <= '0;
            isr_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            mask_q        <= mask_d;
            prev_q        <= ints;
            en_q          <= en_d;
            rr_ptr_q      <= rr_ptr_d;
            int_pending_q <= int_pending_d;
            in_service_q  <= in_service_d;
            int_id_q      <= int_id_d;
            isr_addr_q    <= isr_addr_d;
        end
    end

    assign int_pending = int_pending_q;
    assign in_service  = in_service_q;
    assign int_id      = int_id_q;
    assign isr_addr    = isr_addr_q;
    assign pend_reg    = pend_q;

endmodule

// File: tb/tb_hvpi_ctrl.sv
// Self-checking bench for hvpi_ctrl (8 channels, base 8'hE0, stride 4).
// Expected grants are queued when requests are stimulated and compared when
// the controller raises int_pending.
module tb_hvpi_ctrl;

    localparam int N   = 8;
    localparam int PCW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   ints;
    logic [N-1:0]   mask_in;
    logic           ld_mask, clr_mask, int_enable, int_disable, rr_mode, ack, eoi;
    logic           int_pending;
    logic [PCW-1:0] isr_addr;
    logic [2:0]     int_id;
    logic           in_service;
    logic [N-1:0]   pend_reg;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] addr;
    } grant_t;

    grant_t sb_q[$];

    hvpi_ctrl #(
        .NUM_INTS   (N),
        .PC_WIDTH   (PCW),
        .VEC_BASE   (32'hE0),
        .VEC_STRIDE (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ints        (ints),
        .mask_in     (mask_in),
        .ld_mask     (ld_mask),
        .clr_mask    (clr_mask),
        .int_enable  (int_enable),
        .int_disable (int_disable),
        .rr_mode     (rr_mode),
        .ack         (ack),
        .eoi         (eoi),
        .int_pending (int_pending),
        .isr_addr    (isr_addr),
        .int_id      (int_id),
        .in_service  (in_service),
        .pend_reg    (pend_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] vec_of(input int id);
        int v;
        v = 'hE0 + id * 4;
        return v[7:0];
    endfunction

    task automatic push_grant(input int id);
        grant_t g;
        g.id   = 3'(id);
        g.addr = vec_of(id);
        sb_q.push_back(g);
    endtask

    // Advance n edges; sample point is 1 time unit after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int ch);
        ints[ch] = 1'b1;
        tick();
        ints[ch] = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    // Wait (bounded) for a request and compare it with the scoreboard head.
    task automatic expect_grant(input string name);
        grant_t exp_g;
        int     waited;
        waited = 0;
        while (!int_pending && waited < 20) begin
            tick();
            waited++;
        end
        total++;
        if (!int_pending) begin
            bad++;
            $display("FAIL %s: no request within 20 cycles, int_pending=%0b want 1", name, int_pending);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected request id=%0d, scoreboard empty", name, int_id);
            return;
        end
        exp_g = sb_q.pop_front();
        if (int_id !== exp_g.id || isr_addr !== exp_g.addr) begin
            bad++;
            $display("FAIL %s: got id=%0d addr=%h want id=%0d addr=%h",
                     name, int_id, isr_addr, exp_g.id, exp_g.addr);
        end
    endtask

    task automatic setup_all();
        mask_in    = 8'hFF;
        ld_mask    = 1'b1;
        int_enable = 1'b1;
        tick();
        ld_mask    = 1'b0;
        int_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        total++;
        if ({int_pending, in_service} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: pending/in_service=%b want 00", {int_pending, in_service});
        end
        total++;
        if (int_id !== 3'd0 || isr_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_vec: id=%0d addr=%h want 0/00", int_id, isr_addr);
        end
        total++;
        if (pend_reg !== 8'h00) begin
            bad++;
            $display("FAIL reset_pend: pend_reg=%h want 00", pend_reg);
        end
    endtask

    task automatic test_basic();
        setup_all();
        push_grant(3);
        pulse(3);
        total++;
        if (int_pending !== 1'b0 || pend_reg !== 8'h08) begin
            bad++;
            $display("FAIL basic_latency1: pending=%b pend=%h want 0/08", int_pending, pend_reg);
        end
        tick();
        total++;
        if (int_pending !== 1'b1 || isr_addr !== 8'hEC) begin
            bad++;
            $display("FAIL basic_latency2: pending=%b addr=%h want 1/EC", int_pending, isr_addr);
        end
        expect_grant("basic_grant");
        do_ack();
        total++;
        if (pend_reg[3] !== 1'b0 || in_service !== 1'b1 || int_pending !== 1'b0) begin
            bad++;
            $display("FAIL basic_ack: pend3=%b in_service=%b pending=%b want 0/1/0",
                     pend_reg[3], in_service, int_pending);
        end
        do_eoi();
        total++;
        if (in_service !== 1'b0) begin
            bad++;
            $display("FAIL basic_eoi: in_service=%b want 0", in_service);
        end
    endtask

    task automatic test_fixed_priority();
        push_grant(2);
        push_grant(5);
        ints[5] = 1'b1;
        ints[2] = 1'b1;
        tick();
        ints = '0;
        expect_grant("fixed_first");
        do_ack();
        do_eoi();
        test_back_to_back();
        do_ack();
        do_eoi();
    endtask

    // Second pending channel must be requested exactly one cycle after eoi.
    task automatic test_back_to_back();
        total++;
        if (int_pending !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: pending=%b want 0 right after eoi", int_pending);
        end
        tick();
        total++;
        if (int_pending !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rise: pending=%b want 1 one cycle after eoi", int_pending);
        end
        expect_grant("fixed_second");
    endtask

    task automatic test_round_robin();
        test_reset();
        setup_all();
        rr_mode = 1'b1;
        push_grant(1);
        push_grant(6);
        push_grant(1);
        push_grant(6);
        ints[1] = 1'b1;
        ints[6] = 1'b1;
        tick();
        ints = '0;
        expect_grant("rr_g1");
        do_ack();
        pulse(1);
        do_eoi();
        expect_grant("rr_g2");
        do_ack();
        pulse(6);
        do_eoi();
        expect_grant("rr_g3");
        do_ack();
        do_eoi();
        expect_grant("rr_g4");
        do_ack();
        do_eoi();
        tick(3);
        total++;
        if (int_pending !== 1'b0 || pend_reg !== 8'h00) begin
            bad++;
            $display("FAIL rr_drain: pending=%b pend=%h want 0/00", int_pending, pend_reg);
        end
        rr_mode = 1'b0;
    endtask

    task automatic test_mask();
        mask_in = 8'hF7;
        ld_mask = 1'b1;
        tick();
        ld_mask = 1'b0;
        pulse(3);
        tick(3);
        total++;
        if (pend_reg[3] !== 1'b1 || int_pending !== 1'b0) begin
            bad++;
            $display("FAIL mask_block: pend3=%b pending=%b want 1/0", pend_reg[3], int_pending);
        end
        push_grant(3);
        mask_in = 8'hFF;
        ld_mask = 1'b1;
        tick();
        ld_mask = 1'b0;
        total++;
        if (int_pending !== 1'b0) begin
            bad++;
            $display("FAIL mask_early: pending=%b want 0 one cycle after load", int_pending);
        end
        tick();
        total++;
        if (int_pending !== 1'b1) begin
            bad++;
            $display("FAIL mask_release: pending=%b want 1 two cycles after load", int_pending);
        end
        expect_grant("mask_grant");
        do_ack();
        do_eoi();
    endtask

    task automatic test_disable();
        pulse(4);
        tick();
        total++;
        if (int_pending !== 1'b1 || int_id !== 3'd4) begin
            bad++;
            $display("FAIL dis_req: pending=%b id=%0d want 1/4", int_pending, int_id);
        end
        int_disable = 1'b1;
        tick();
        int_disable = 1'b0;
        total++;
        if (int_pending !== 1'b0 || pend_reg[4] !== 1'b1) begin
            bad++;
            $display("FAIL dis_drop: pending=%b pend4=%b want 0/1", int_pending, pend_reg[4]);
        end
        tick(3);
        total++;
        if (int_pending !== 1'b0) begin
            bad++;
            $display("FAIL dis_quiet: pending=%b want 0 while disabled", int_pending);
        end
        push_grant(4);
        int_enable = 1'b1;
        tick();
        int_enable = 1'b0;
        expect_grant("dis_reissue");
        do_ack();
        do_eoi();
    endtask

    task automatic test_edge_cases();
        // Level-held line: one request only.
        push_grant(0);
        ints[0] = 1'b1;
        expect_grant("held_grant");
        do_ack();
        do_eoi();
        tick(7);
        total++;
        if (int_pending !== 1'b0 || pend_reg[0] !== 1'b0) begin
            bad++;
            $display("FAIL held_once: pending=%b pend0=%b want 0/0", int_pending, pend_reg[0]);
        end
        ints[0] = 1'b0;
        tick();

        // Ack coinciding with a fresh edge on the same channel.
        push_grant(0);
        pulse(0);
        expect_grant("ackedge_grant");
        ints[0] = 1'b1;
        ack     = 1'b1;
        tick();
        ack     = 1'b0;
        ints[0] = 1'b0;
        total++;
        if (pend_reg[0] !== 1'b1 || in_service !== 1'b1) begin
            bad++;
            $display("FAIL ackedge_keep: pend0=%b in_service=%b want 1/1", pend_reg[0], in_service);
        end
        push_grant(0);
        do_eoi();
        expect_grant("ackedge_regrant");
        do_ack();
        do_eoi();

        // Spurious ack/eoi in IDLE: nothing changes.
        ack = 1'b1;
        eoi = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b0;
        total++;
        if (in_service !== 1'b0 || int_pending !== 1'b0) begin
            bad++;
            $display("FAIL spurious: in_service=%b pending=%b want 0/0", in_service, int_pending);
        end

        // Reset while servicing, with another channel pending.
        push_grant(7);
        pulse(7);
        expect_grant("rst_grant");
        do_ack();
        pulse(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({int_pending, in_service, int_id, isr_addr, pend_reg} !== '0) begin
            bad++;
            $display("FAIL rst_service: pend=%b svc=%b id=%0d addr=%h pend_reg=%h want all 0",
                     int_pending, in_service, int_id, isr_addr, pend_reg);
        end
        tick(3);
        total++;
        if (int_pending !== 1'b0) begin
            bad++;
            $display("FAIL rst_quiet: pending=%b want 0 after reset", int_pending);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ints        = '0;
        mask_in     = '0;
        ld_mask     = 1'b0;
        clr_mask    = 1'b0;
        int_enable  = 1'b0;
        int_disable = 1'b0;
        rr_mode     = 1'b0;
        ack         = 1'b0;
        eoi         = 1'b0;

        test_reset();
        test_basic();
        test_fixed_priority();
        test_round_robin();
        test_mask();
        test_disable();
        test_edge_cases();

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: %0d grants never seen, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hvpi_ctrl.md
Name: hvpi_ctrl

Overview:
Parametrised successor to the processor's hardware vectored priority interrupt (HVPI) system. It generalises channel count, vector base and vector stride, and adds rising-edge request latching, selectable fixed or round-robin priority, and an explicit request/acknowledge/end-of-interrupt service cycle. It sits between the external and internal interrupt sources and the ControllerSeq. It supplies the ISR address to the PC input mux.

Parameters:
NUM_INTS, 8, number of interrupt channels (2..16).
PC_WIDTH, 8, width of the ISR address output.
VEC_BASE, 8'hE0, ISR address of channel 0.
VEC_STRIDE, 4, address spacing between consecutive channel vectors.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
ints  input  NUM_INTS  raw interrupt request lines; rising-edge sensitive.
mask_in  input  NUM_INTS  mask value to load; 1 = channel enabled.
ld_mask  input  1  load mask register from mask_in.
clr_mask  input  1  clear mask register (all channels masked).
int_enable  input  1  set global enable.
int_disable  input  1  clear global enable.
rr_mode  input  1  0 = fixed priority (index 0 highest); 1 = round-robin.
ack  input  1  controller accepts the pending interrupt.
eoi  input  1  end of interrupt service (RETI).
int_pending  output  1  request to the controller.
isr_addr  output  PC_WIDTH  vector of the selected channel.
int_id  output  $clog2(NUM_INTS)  index of the selected channel.
in_service  output  1  an ISR is currently executing.
pend_reg  output  NUM_INTS  latched pending bits (debug).

Behaviour:
- Reset: all outputs are 0. The following state also resets to 0: pend_reg, mask, previous-ints register, global enable, round-robin pointer. FSM state resets to IDLE.
- Edge detect: prev <= ints every cycle. pend[i] is set when ints[i] & ~prev[i].
  - Pend bits set regardless of mask or enable.
  - If a set and an ack-clear hit the same bit in the same cycle, the set wins.
- Mask register: clr_mask takes priority over ld_mask.
- Global enable: int_disable takes priority over int_enable.
- Eligible set: pend & mask. Global enable gates selection only.
- Selection:
  - Fixed mode: the lowest eligible index wins.
  - Round-robin mode: the first eligible index found searching upward from rr_ptr, with wrap-around.
- Vector: isr_addr = VEC_BASE + id*VEC_STRIDE, truncated modulo 2^PC_WIDTH.
- FSM states:
  - IDLE: if enable & |eligible, latch int_id and isr_addr, assert int_pending, go to REQ.
  - REQ: int_pending = 1; int_id and isr_addr are held.
    - On ack: clear pend[int_id], int_pending <= 0, in_service <= 1, go to SERVICE.
    - If enable drops or mask[int_id] becomes 0 before ack: int_pending <= 0, go to IDLE; the pend bit is retained.
  - SERVICE: no new request is issued (no nesting), and int_id and isr_addr are held.
    - On eoi: in_service <= 0, rr_ptr <= (int_id+1) mod NUM_INTS, go to IDLE.
- Spurious inputs: ack outside REQ is ignored, and eoi outside SERVICE is ignored.
- Latency: ints[i] rises before clock edge k, which sets pend[i] after edge k. int_pending is 1 after edge k+1, so a request appears 2 cycles after the input rises.
- Back-to-back: after eoi, the next eligible request raises int_pending 1 cycle after returning to IDLE.
- Level-held inputs: a line held high produces no further requests until it falls and rises again.
- Reset mid-operation: returns to IDLE, drops int_pending and in_service, and discards all pending bits.

Test Plan:
1. reset; enable; mask=8'hFF; rr_mode=0; pulse ints[3] -> int_pending=1 exactly 2 cycles later, int_id=3, isr_addr=8'hEC. Then ack -> pend_reg[3]=0, in_service=1. Then eoi -> in_service=0.
2. Fixed priority: ints[5] and ints[2] rise together -> first service is id 2 (8'hE8). After eoi, id 5 (8'hF4) is requested.
3. Round-robin: rr_mode=1; hold pend on channels 1 and 6 by re-pulsing each after it is serviced -> grant order is 1, 6, 1, 6.
4. Masking: mask=8'hF7; pulse ints[3] -> pend_reg[3]=1 but no int_pending. Then load mask=8'hFF -> int_pending=1 two cycles later with id 3.
5. int_disable asserted while in REQ -> int_pending=0 next cycle and pend_reg retained. Re-enable -> the request reissues with the same id.
6. Edge cases:
   - ints[0] held high for 10 cycles -> only one request.
   - ack coinciding with a new ints[0] edge -> pend_reg[0] remains 1.
   - reset asserted during SERVICE -> all outputs are 0 next cycle.
